mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single synchronous memory port of the FPGA system top between three requesters: CPU instruction fetch, CPU load/store, and a debug program loader. The loader replaces hierarchical memory pokes for program download. Arbitration is fixed-priority for the loader and round-robin between fetch and data. The block sits between the microcoded CPU and the RAM, which has a 1-cycle read latency.

Parameters:
ADDR_WIDTH, 10, word-address width of all address ports.
DATA_WIDTH, 32, data width; must be a multiple of 8.
MEM_DEPTH, 1024, number of implemented words; addresses >= MEM_DEPTH are out of range.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
if_req  in  1  fetch read request; held with if_addr until if_gnt.
if_addr  in  ADDR_WIDTH  fetch word address.
if_gnt  out  1  fetch request accepted this cycle.
if_rvalid  out  1  fetch read data valid, one-cycle pulse.
if_rdata  out  DATA_WIDTH  fetch read data.
d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt.
d_we  in  1  1 = write, 0 = read.
d_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
d_addr  in  ADDR_WIDTH  data word address.
d_wdata  in  DATA_WIDTH  write data.
d_gnt  out  1  data request accepted.
d_rvalid  out  1  data read data valid, one-cycle pulse (reads only).
d_rdata  out  DATA_WIDTH  data read data.
ld_req  in  1  loader full-word write request.
ld_addr  in  ADDR_WIDTH  loader address.
ld_wdata  in  DATA_WIDTH  loader data.
ld_gnt  out  1  loader write accepted.
mem_en  out  1  memory access strobe.
mem_we  out  DATA_WIDTH/8  per-byte write enable; all zero for reads.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read strobe.
addr_err  out  1  one-cycle pulse: the access granted in the previous cycle was out of range.

Behaviour:
- Reset values (rst low, asynchronous): all gnt/rvalid/addr_err = 0, mem_en = 0, mem_we = 0, rr pointer = fetch-preferred, response pipeline empty. if_rdata and d_rdata = 0.
- Arbitration is combinational in cycle N from the req inputs and the registered rr pointer.
  - ld_req always wins.
  - Otherwise, if only one of if_req/d_req is high, it wins.
  - If both are high, the rr side wins and rr toggles to the other side at the clock edge.
  - rr updates only on an if/data contention grant.
- At most one gnt per cycle. gnt is high in the same cycle as mem_en for that access. Back-to-back grants every cycle are allowed, with full throughput.
- Memory drive in cycle N: mem_addr, mem_wdata and mem_we come from the winner.
  - Loader writes use mem_we all-ones.
  - Data writes use mem_we = d_be.
  - Reads use mem_we = 0.
- Out-of-range access (addr >= MEM_DEPTH):
  - Granted normally, but mem_en stays 0 and mem_we stays 0.
  - In cycle N+1, addr_err pulses.
  - For reads, the requester's rvalid pulses in N+1 with rdata = 0.
- Read response: a registered owner tag (none/fetch/data) plus an out-of-range flag are captured at the edge after grant.
  - In N+1, the owner's rvalid = 1 and its rdata = mem_rdata (or 0 if out of range).
  - The other requester's rdata holds its last value.
- Writes produce no rvalid.
- Requesters must not drop req before gnt. Dropping req is treated as withdrawal; no response is issued.
- Reset mid-operation: any pending response is discarded. No rvalid appears after rst deassertion unless a new grant occurs.

Test Plan:
- Reset: rst=0 with all reqs high -> all gnt, rvalid, mem_en and addr_err are 0. Release rst; first cycle: ld_gnt=1.
- Loader priority: ld_req held 3 cycles writing 0x00100 0B7, 0x1, 0x2 to addrs 0..2 while if_req=1 -> ld_gnt 3 cycles, mem_we=4'hF, if_gnt only in cycle 4.
- Round-robin: if_req and d_req high for 4 cycles, reads at addr 0/1 after reset -> grant order fetch, data, fetch, data. Each rvalid comes one cycle after its grant with the loaded data (0x001000B7 for addr 0).
- Byte write: d_we=1, d_be=4'b0010, d_addr=5, d_wdata=0xAABBCCDD, then read addr 5 -> mem_we=4'b0010, no d_rvalid on the write. Read returns only byte1 = 0xCC changed.
- Out of range: if_req with if_addr=1023 and MEM_DEPTH=1000 -> if_gnt=1, mem_en=0. Next cycle: if_rvalid=1, if_rdata=0, addr_err=1.
- Reset mid-read: d_gnt for a read at cycle N, rst low at N+0.5 -> d_rvalid stays 0 through and after reset release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, loader and RAM-port signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_gnt;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;
  logic                    d_req;
  logic                    d_we;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;
  logic                    ld_req;
  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic [DATA_WIDTH-1:0]   ld_wdata;
  logic                    ld_gnt;
  logic                    mem_en;
  logic [DATA_WIDTH/8-1:0] mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    addr_err;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ld_req, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ld_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, addr_err
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ld_req, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ld_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, addr_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM port between fetch, load/store and the debug loader.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  owner_e owner_q, owner_d;
  logic rr_q, rr_d;
  logic oor_q, oor_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q, resp;
  logic gnt_ld, gnt_if, gnt_d, gnt_any, contend;
  logic [ADDR_WIDTH-1:0] addr;
  // rr_q = 1 means the data side wins the next fetch/data contention
  always_comb begin
    gnt_ld = rst && bus.ld_req;
    gnt_if = rst && !bus.ld_req && bus.if_req && (!bus.d_req || !rr_q);
    gnt_d = rst && !bus.ld_req && bus.d_req && (!bus.if_req || rr_q);
    gnt_any = gnt_ld || gnt_if || gnt_d;
    contend = rst && !bus.ld_req && bus.if_req && bus.d_req;
    addr = gnt_ld ? bus.ld_addr : gnt_d ? bus.d_addr : bus.if_addr;
    oor_d = gnt_any && (32'(addr) >= MEM_DEPTH);
    rr_d = contend ? gnt_if : rr_q;
    owner_d = gnt_if ? OWN_IF : (gnt_d && !bus.d_we) ? OWN_D : OWN_NONE;
    bus.ld_gnt = gnt_ld;
    bus.if_gnt = gnt_if;
    bus.d_gnt = gnt_d;
    bus.mem_en = gnt_any && !oor_d;
    bus.mem_we = !bus.mem_en ? '0 : gnt_ld ? '1 : (gnt_d && bus.d_we) ? bus.d_be : '0;
    bus.mem_addr = addr;
    bus.mem_wdata = gnt_ld ? bus.ld_wdata : bus.d_wdata;
    resp = oor_q ? '0 : bus.mem_rdata;
    bus.if_rvalid = owner_q == OWN_IF;
    bus.d_rvalid = owner_q == OWN_D;
    bus.if_rdata = bus.if_rvalid ? resp : if_rdata_q;
    bus.d_rdata = bus.d_rvalid ? resp : d_rdata_q;
    bus.addr_err = oor_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
      owner_q <= OWN_NONE;
      oor_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      rr_q <= rr_d;
      owner_q <= owner_d;
      oor_q <= oor_d;
      if_rdata_q <= bus.if_rdata;
      d_rdata_q <= bus.d_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural port model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus();
  mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // RAM with one-cycle read latency attached to the arbiter's memory port
  logic [31:0] ram [0:1023] = '{default: '0};
  logic [31:0] ram_rd = '0;
  assign bus.mem_rdata = ram_rd;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      ram_rd <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++) if (bus.mem_we[b]) ram[bus.mem_addr][8*b+:8] <= bus.mem_wdata[8*b+:8];
    end
  end
  logic [31:0] ref_mem [0:1023];

  function automatic logic [9:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    bus.if_req = 0; bus.d_req = 0; bus.ld_req = 0;
  endtask

  task automatic test_reset();
    bus.if_req = 1; bus.if_addr = 0; bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 0; bus.d_wdata = 0;
    bus.ld_req = 1; bus.ld_addr = 0; bus.ld_wdata = 32'h001000B7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({bus.ld_gnt, bus.if_gnt, bus.d_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", {bus.ld_gnt, bus.if_gnt, bus.d_gnt}); end
    n_chk++; if ({bus.if_rvalid, bus.d_rvalid, bus.addr_err, bus.mem_en} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.if_rvalid, bus.d_rvalid, bus.addr_err, bus.mem_en}); end
    n_chk++; if (bus.mem_we !== 4'h0) begin n_fail++; $display("FAIL reset_mem_we got %h want 0", bus.mem_we); end
    n_chk++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", {bus.if_rdata, bus.d_rdata}); end
    #2 rst = 1;
    #1;
    n_chk++; if ({bus.ld_gnt, bus.if_gnt, bus.d_gnt} !== 3'b100) begin n_fail++; $display("FAIL release_gnt got %b want 100", {bus.ld_gnt, bus.if_gnt, bus.d_gnt}); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_loader_priority();
    logic [31:0] vals [3] = '{32'h001000B7, 32'h1, 32'h2};
    bus.if_req = 1; bus.if_addr = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_req = 1; bus.ld_addr = 10'(i); bus.ld_wdata = vals[i];
      @(negedge clk);
      n_chk++; if ({bus.ld_gnt, bus.if_gnt} !== 2'b10) begin n_fail++; $display("FAIL ld_prio_gnt[%0d] got %b want 10", i, {bus.ld_gnt, bus.if_gnt}); end
      n_chk++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'hF, 10'(i), vals[i]}) begin n_fail++; $display("FAIL ld_prio_mem[%0d] en=%b we=%h addr=%0d wd=%h", i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      @(posedge clk); #1;
    end
    bus.ld_req = 0;
    @(negedge clk);
    n_chk++; if ({bus.ld_gnt, bus.if_gnt, bus.mem_en, bus.mem_we} !== 7'b0110000) begin n_fail++; $display("FAIL ld_prio_fetch got ld=%b if=%b en=%b we=%h want 0 1 1 0", bus.ld_gnt, bus.if_gnt, bus.mem_en, bus.mem_we); end
    @(posedge clk); #1;
    bus.if_req = 0;
    @(negedge clk);
    n_chk++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h001000B7}) begin n_fail++; $display("FAIL ld_prio_read got v=%b d=%h want 1 001000b7", bus.if_rvalid, bus.if_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    bus.if_req = 1; bus.if_addr = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++; if ({bus.if_gnt, bus.d_gnt} !== {k % 2 == 0, k % 2 == 1}) begin n_fail++; $display("FAIL rr_gnt[%0d] got if=%b d=%b", k, bus.if_gnt, bus.d_gnt); end
      n_chk++; if ({bus.if_rvalid, bus.d_rvalid} !== {k % 2 == 1, k > 0 && k % 2 == 0}) begin n_fail++; $display("FAIL rr_rvalid[%0d] got if=%b d=%b", k, bus.if_rvalid, bus.d_rvalid); end
      if (k % 2 == 1) begin n_chk++; if (bus.if_rdata !== 32'h001000B7) begin n_fail++; $display("FAIL rr_if_rdata[%0d] got %h want 001000b7", k, bus.if_rdata); end end
      if (k > 0 && k % 2 == 0) begin n_chk++; if (bus.d_rdata !== 32'h1) begin n_fail++; $display("FAIL rr_d_rdata[%0d] got %h want 1", k, bus.d_rdata); end end
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    n_chk++; if ({bus.if_rvalid, bus.d_rvalid, bus.d_rdata, bus.if_rdata} !== {2'b01, 32'h1, 32'h001000B7}) begin n_fail++; $display("FAIL rr_tail got iv=%b dv=%b dd=%h id=%h", bus.if_rvalid, bus.d_rvalid, bus.d_rdata, bus.if_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    bus.ld_req = 1; bus.ld_addr = 5; bus.ld_wdata = 32'h11223344;
    @(negedge clk);
    n_chk++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL bw_preload ld_gnt got %b want 1", bus.ld_gnt); end
    @(posedge clk); #1;
    bus.ld_req = 0; bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0010; bus.d_addr = 5; bus.d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    n_chk++; if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_wdata} !== {2'b11, 4'b0010, 32'hAABBCCDD}) begin n_fail++; $display("FAIL bw_write got gnt=%b en=%b we=%b wd=%h", bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_wdata); end
    @(posedge clk); #1;
    bus.d_we = 0;
    @(negedge clk);
    n_chk++; if ({bus.d_rvalid, bus.d_gnt, bus.mem_we} !== {2'b01, 4'h0}) begin n_fail++; $display("FAIL bw_read_issue got rv=%b gnt=%b we=%h want 0 1 0", bus.d_rvalid, bus.d_gnt, bus.mem_we); end
    @(posedge clk); #1;
    bus.d_req = 0;
    @(negedge clk);
    n_chk++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h1122CC44}) begin n_fail++; $display("FAIL bw_readback got v=%b d=%h want 1 1122cc44", bus.d_rvalid, bus.d_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    bus.if_req = 1; bus.if_addr = 1023;
    @(negedge clk);
    n_chk++; if ({bus.if_gnt, bus.mem_en, bus.mem_we} !== 6'b100000) begin n_fail++; $display("FAIL oor_fetch_grant got gnt=%b en=%b we=%h want 1 0 0", bus.if_gnt, bus.mem_en, bus.mem_we); end
    @(posedge clk); #1;
    bus.if_req = 0;
    @(negedge clk);
    n_chk++; if ({bus.if_rvalid, bus.addr_err, bus.if_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL oor_fetch_resp got v=%b err=%b d=%h want 1 1 0", bus.if_rvalid, bus.addr_err, bus.if_rdata); end
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF; bus.d_addr = 1000; bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++; if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.addr_err} !== 7'b1000000) begin n_fail++; $display("FAIL oor_write got gnt=%b en=%b we=%h err=%b", bus.d_gnt, bus.mem_en, bus.mem_we, bus.addr_err); end
    @(posedge clk); #1;
    bus.d_addr = 999; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    n_chk++; if ({bus.addr_err, bus.d_rvalid, bus.mem_en, bus.mem_we} !== 7'b1011111) begin n_fail++; $display("FAIL oor_edge got err=%b rv=%b en=%b we=%h want 1 0 1 f", bus.addr_err, bus.d_rvalid, bus.mem_en, bus.mem_we); end
    @(posedge clk); #1;
    bus.d_req = 0;
    @(negedge clk);
    n_chk++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_in_range_err got %b want 0", bus.addr_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 0;
    @(negedge clk);
    n_chk++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt got %b want 1", bus.d_gnt); end
    rst = 0; bus.d_req = 0;
    #1;
    n_chk++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_during got %b want 0", bus.d_rvalid); end
    @(posedge clk); #1;
    n_chk++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_edge got %b want 0", bus.d_rvalid); end
    @(negedge clk);
    rst = 1;
    #1;
    n_chk++; if ({bus.d_rvalid, bus.d_rdata} !== 33'h0) begin n_fail++; $display("FAIL rmr_release got v=%b d=%h want 0 0", bus.d_rvalid, bus.d_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_after[%0d] got %b want 0", i, bus.d_rvalid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic data_pref = 0;
    logic e_iv = 0, e_dv = 0, e_err = 0;
    logic [31:0] e_ird = 0, e_drd = 0;
    int w;
    logic [9:0] a;
    logic oor;
    logic [3:0] we;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    ref_mem[0] = 32'h001000B7; ref_mem[1] = 1; ref_mem[2] = 2; ref_mem[5] = 32'h1122CC44; ref_mem[999] = 32'h12345678;
    for (int n = 0; n < 400; n++) begin
      bus.ld_req = ($urandom_range(0, 5) == 0); bus.ld_addr = rnd_addr(); bus.ld_wdata = $urandom;
      bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = rnd_addr();
      bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1)); bus.d_be = 4'($urandom_range(0, 15));
      bus.d_addr = rnd_addr(); bus.d_wdata = $urandom;
      @(negedge clk);
      n_chk++; if ({bus.if_rvalid, bus.d_rvalid, bus.addr_err} !== {e_iv, e_dv, e_err}) begin n_fail++; $display("FAIL rnd_resp[%0d] got iv=%b dv=%b err=%b want %b %b %b", n, bus.if_rvalid, bus.d_rvalid, bus.addr_err, e_iv, e_dv, e_err); end
      n_chk++; if ({bus.if_rdata, bus.d_rdata} !== {e_ird, e_drd}) begin n_fail++; $display("FAIL rnd_rdata[%0d] got if=%h d=%h want %h %h", n, bus.if_rdata, bus.d_rdata, e_ird, e_drd); end
      w = bus.ld_req ? 1 : (bus.if_req && bus.d_req) ? (data_pref ? 3 : 2) : bus.if_req ? 2 : bus.d_req ? 3 : 0;
      a = (w == 1) ? bus.ld_addr : (w == 3) ? bus.d_addr : bus.if_addr;
      oor = (w != 0) && (int'(a) >= 1000);
      we = (w == 0 || oor) ? 4'h0 : (w == 1) ? 4'hF : (w == 3 && bus.d_we) ? bus.d_be : 4'h0;
      n_chk++; if ({bus.ld_gnt, bus.if_gnt, bus.d_gnt} !== {w == 1, w == 2, w == 3}) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b%b%b want winner %0d", n, bus.ld_gnt, bus.if_gnt, bus.d_gnt, w); end
      n_chk++; if ({bus.mem_en, bus.mem_we} !== {w != 0 && !oor, we}) begin n_fail++; $display("FAIL rnd_mem[%0d] got en=%b we=%h want %b %h", n, bus.mem_en, bus.mem_we, w != 0 && !oor, we); end
      if (w != 0) begin n_chk++; if (bus.mem_addr !== a) begin n_fail++; $display("FAIL rnd_addr[%0d] got %0d want %0d", n, bus.mem_addr, a); end end
      if (we != 0) begin n_chk++; if (bus.mem_wdata !== ((w == 1) ? bus.ld_wdata : bus.d_wdata)) begin n_fail++; $display("FAIL rnd_wdata[%0d] got %h", n, bus.mem_wdata); end end
      if (!bus.ld_req && bus.if_req && bus.d_req) data_pref = (w == 2);
      e_iv = (w == 2);
      e_dv = (w == 3) && !bus.d_we;
      e_err = oor;
      if (e_iv) e_ird = oor ? 0 : ref_mem[a];
      if (e_dv) e_drd = oor ? 0 : ref_mem[a];
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a][8*b+:8] = bus.mem_wdata[8*b+:8];
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_loader_priority();
    test_round_robin();
    test_byte_write();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
